// File: rtl/rate_tick_pkg.sv
// rate_tick_pkg: shared defaults and rate-select encodings for rate_tick_gen
package rate_tick_pkg;
  localparam int unsigned CNT_W_DEF       = 28;
  localparam int unsigned DIV0_DEF        = 2;
  localparam int unsigned DIV1_DEF        = 50_000_000;
  localparam int unsigned DIV2_DEF        = 100_000_000;
  localparam int unsigned DIV3_DEF        = 200_000_000;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  typedef enum logic [1:0] {
    RATE_FAST = 2'b00,
    RATE_1S   = 2'b01,
    RATE_2S   = 2'b10,
    RATE_4S   = 2'b11
  } rate_e;
endpackage

// File: rtl/rate_tick_gen_sel_synchronizer.sv
// sel_synchronizer: STAGES-deep 2-bit flop chain bringing the async rate switches into the clock domain
module sel_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  output logic [1:0] q
);
  logic [STAGES-1:0][1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: one-cycle tick every DIV[rate_idx] clocks; define RATE_SQUARE_OUT_EN for the sq square-wave output
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DIV0        = DIV0_DEF,
  parameter int unsigned DIV1        = DIV1_DEF,
  parameter int unsigned DIV2        = DIV2_DEF,
  parameter int unsigned DIV3        = DIV3_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] sel,
  output logic       tick,
  output logic [1:0] rate_idx,
  output logic       sq
);
  localparam logic [CNT_W-1:0] T0 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] T1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] T2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] T3 = CNT_W'(DIV3 - 1);
  logic [1:0]       sel_s;
  rate_e            rate_idx_q, rate_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, term;
  logic             tick_q, tick_d, chg, at_term;
  sel_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (CLOCK_50),
    .rst (reset),
    .d   (sel),
    .q   (sel_s)
  );
  // A committed rate change restarts the period and suppresses any tick due on that edge
  always_comb begin
    term       = rate_idx_q == RATE_FAST ? T0 : rate_idx_q == RATE_1S ? T1 : rate_idx_q == RATE_2S ? T2 : T3;
    chg        = sel_s != rate_idx_q;
    at_term    = cnt_q == term;
    rate_idx_d = rate_e'(sel_s);
    cnt_d      = chg ? '0 : !enable ? cnt_q : at_term ? '0 : cnt_q + 1'b1;
    tick_d     = !chg && enable && at_term;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rate_idx_q <= RATE_FAST;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      rate_idx_q <= rate_idx_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
    end
  end
  assign tick     = tick_q;
  assign rate_idx = rate_idx_q;
`ifdef RATE_SQUARE_OUT_EN
  logic sq_q, sq_d;
  always_comb sq_d = sq_q ^ tick_d;
  always_ff @(posedge CLOCK_50) begin
    if (reset) sq_q <= 1'b0;
    else       sq_q <= sq_d;
  end
  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif
endmodule
